bus_master_if: RTL
==================

// Module: bus_master_if
// PURPOSE
//  Per-master bus interface between a CPU pipeline stage and the shared bus fabric (arbiter/master mux).
//  Converts a level-held CPU access into the bus request/grant/strobe/ready protocol.
//  Registers the read data and holds it while the pipeline is stalled.
//  Produces busy to stall the pipeline. One instance per bus master (m0..m3).
// PARAMETERS
//  ADDR_W   30   word-address width (matches WORD_ADDR_BUS)
//  DATA_W   32   data width (matches WORD_DATA_BUS)
// PORTS
//  clk          in   1       system clock, all logic on rising edge
//  reset        in   1       synchronous, active-low reset
//  stall        in   1       pipeline stall; CPU holds request fields while high
//  flush        in   1       pipeline flush; cancels a not-yet-granted access
//  cpu_as_n     in   1       CPU access strobe, active-low, level-held until busy=0
//  cpu_rw       in   1       READ=1 / WRITE=0
//  cpu_addr     in   ADDR_W  word address
//  cpu_wr_data  in   DATA_W  write data
//  cpu_rd_data  out  DATA_W  read data, valid when busy=0 after a read
//  busy         out  1       access in progress, CPU must stall
//  bus_req_n    out  1       to arbiter, active-low
//  bus_grnt_n   in   1       from arbiter, active-low
//  bus_addr     out  ADDR_W  to master mux
//  bus_as_n     out  1       address strobe, active-low, one cycle
//  bus_rw       out  1       READ/WRITE
//  bus_wr_data  out  DATA_W  write data
//  bus_rd_data  in   DATA_W  shared m_rd_data
//  bus_rdy_n    in   1       shared m_rdy_n, active-low
// BEHAVIOUR
//  Reset (reset=0 at edge): state=IDLE; bus_req_n=1, bus_as_n=1, bus_rw=READ, bus_addr=0, bus_wr_data=0, rd_buf=0.
//  - Reset in any state aborts the transaction. The bus request is released on the next cycle.
//  All bus_* outputs are registered. busy and cpu_rd_data are combinational.
//  States:
//  - IDLE: when cpu_as_n=0 and flush=0 -> latch addr/rw/wr_data, bus_req_n<=0, go REQ.
//    - When flush=1, the request is ignored and the state stays IDLE.
//  - REQ: when flush=1 -> bus_req_n<=1, go IDLE (request withdrawn, no strobe issued).
//    - Otherwise, when bus_grnt_n=0 -> bus_as_n<=0, drive the latched fields, go ACCESS.
//    - Flush has priority over grant in the same cycle.
//  - ACCESS: bus_as_n<=1 after its single cycle. Fields are held until completion.
//    - When bus_rdy_n=0 and the access is a read -> rd_buf<=bus_rd_data.
//    - When bus_rdy_n=0 -> bus_req_n<=1; go WAIT if stall=1, else IDLE.
//    - Flush is ignored in ACCESS: a granted access always completes.
//    - The ready may arrive in the first ACCESS cycle (zero-wait slave).
//  - WAIT: busy=0, rd_buf held, no new request even though cpu_as_n is still 0. Go IDLE when stall=0.
//  busy equations:
//  - busy = (IDLE & ~cpu_as_n & ~flush) | REQ | (ACCESS & bus_rdy_n).
//  cpu_rd_data equations:
//  - cpu_rd_data = (ACCESS & ~bus_rdy_n & rw==READ) ? bus_rd_data : rd_buf.
//  Latency (uncontended):
//  - request edge -> bus_req_n low: 1 cycle
//  - grant seen -> bus_as_n low: 1 cycle
//  - ready -> busy low: same cycle
//  Back-to-back accesses: IDLE after completion accepts the next cpu_as_n in the following cycle. There is no bubble beyond the IDLE cycle.
//  The write path never updates rd_buf.
//  Loss of grant during ACCESS is a protocol violation. It is not handled and is flagged by an assertion.
// STRUCTURE
//  Shared in bus_def:
//  - state codes BUS_IF_IDLE/REQ/ACCESS/WAIT (2 bits)
//  - READ/WRITE
//  - ENABLE_N/DISABLE_N
//  - WORD_ADDR_BUS/WORD_DATA_BUS
//  Single flat module; no natural sub-module. bus_top stays unchanged.
// TESTING
//  1. Read, grant immediate, rdy_n low 2 cycles after as_n, addr=0x0000_0004, rd_data=0xDEADBEEF
//     -> req_n low 1 cycle after cpu_as_n, a single-cycle as_n
//     -> busy falls with rdy; cpu_rd_data=0xDEADBEEF.
//  2. Write addr=0x10, wr_data=0x12345678, grant delayed 3 cycles
//     -> bus_as_n held high until grant+1, fields stable through ACCESS
//     -> rd_buf unchanged.
//  3. Read completes with stall=1 for 4 cycles
//     -> WAIT state, busy=0, no second req_n, cpu_rd_data held
//     -> IDLE after stall falls.
//  4. Flush in REQ before grant -> req_n returns high next cycle, no as_n pulse.
//     Flush in ACCESS -> access completes normally.
//  5. Reset asserted in ACCESS -> next cycle req_n=1, as_n=1, busy=0, rd_buf=0.
//  6. Zero-wait slave (rdy_n low in first ACCESS cycle), back-to-back reads 0x20, 0x24
//     -> two as_n pulses 3 cycles apart, correct data each.

Source files
------------

// File: rtl/bus_master_if_pkg.sv
// Shared bus definitions: interface state codes, access direction and active-low strobe levels.
package bus_master_if_pkg;

  localparam int WORD_ADDR_W = 30;
  localparam int WORD_DATA_W = 32;

  localparam logic READ      = 1'b1;
  localparam logic WRITE     = 1'b0;
  localparam logic ENABLE_N  = 1'b0;
  localparam logic DISABLE_N = 1'b1;

  typedef enum logic [1:0] {
    BUS_IF_IDLE   = 2'd0,
    BUS_IF_REQ    = 2'd1,
    BUS_IF_ACCESS = 2'd2,
    BUS_IF_WAIT   = 2'd3
  } bus_if_state_e;

endpackage

// File: rtl/bus_master_if.sv
// Per-master bus interface: turns a level-held CPU access into req/grant/strobe/ready handshakes.
// Bus outputs are registered; busy and cpu_rd_data are combinational so ready releases the stall in-cycle.
module bus_master_if
  import bus_master_if_pkg::*;
#(
  parameter int ADDR_W = WORD_ADDR_W,
  parameter int DATA_W = WORD_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              cpu_as_n,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic              busy,
  output logic              bus_req_n,
  input  logic              bus_grnt_n,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_as_n,
  output logic              bus_rw,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_n
);

  bus_if_state_e     state_q, state_d;
  logic              bus_req_n_q, bus_req_n_d;
  logic              bus_as_n_q, bus_as_n_d;
  logic              bus_rw_q, bus_rw_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wr_data_q, bus_wr_data_d;
  logic [DATA_W-1:0] rd_buf_q, rd_buf_d;

  always_comb begin
    state_d       = state_q;
    bus_req_n_d   = bus_req_n_q;
    bus_as_n_d    = bus_as_n_q;
    bus_rw_d      = bus_rw_q;
    bus_addr_d    = bus_addr_q;
    bus_wr_data_d = bus_wr_data_q;
    rd_buf_d      = rd_buf_q;
    busy          = 1'b0;
    cpu_rd_data   = rd_buf_q;

    case (state_q)
      BUS_IF_IDLE: begin
        if (cpu_as_n == ENABLE_N && !flush) begin
          bus_addr_d    = cpu_addr;
          bus_rw_d      = cpu_rw;
          bus_wr_data_d = cpu_wr_data;
          bus_req_n_d   = ENABLE_N;
          state_d       = BUS_IF_REQ;
          busy          = 1'b1;
        end
      end
      BUS_IF_REQ: begin
        busy = 1'b1;
        // Flush wins over a same-cycle grant: the access must not reach the bus.
        if (flush) begin
          bus_req_n_d = DISABLE_N;
          state_d     = BUS_IF_IDLE;
        end else if (bus_grnt_n == ENABLE_N) begin
          bus_as_n_d = ENABLE_N;
          state_d    = BUS_IF_ACCESS;
        end
      end
      BUS_IF_ACCESS: begin
        bus_as_n_d = DISABLE_N;
        if (bus_rdy_n == ENABLE_N) begin
          bus_req_n_d = DISABLE_N;
          if (bus_rw_q == READ) begin
            rd_buf_d    = bus_rd_data;
            cpu_rd_data = bus_rd_data;
          end
          state_d = stall ? BUS_IF_WAIT : BUS_IF_IDLE;
        end else begin
          busy = 1'b1;
        end
      end
      BUS_IF_WAIT: begin
        // The CPU still holds cpu_as_n low for the finished access; only stall release moves on.
        if (!stall) begin
          state_d = BUS_IF_IDLE;
        end
      end
      default: state_d = BUS_IF_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= BUS_IF_IDLE;
      bus_req_n_q   <= DISABLE_N;
      bus_as_n_q    <= DISABLE_N;
      bus_rw_q      <= READ;
      bus_addr_q    <= '0;
      bus_wr_data_q <= '0;
      rd_buf_q      <= '0;
    end else begin
      state_q       <= state_d;
      bus_req_n_q   <= bus_req_n_d;
      bus_as_n_q    <= bus_as_n_d;
      bus_rw_q      <= bus_rw_d;
      bus_addr_q    <= bus_addr_d;
      bus_wr_data_q <= bus_wr_data_d;
      rd_buf_q      <= rd_buf_d;
    end
  end

  assign bus_req_n   = bus_req_n_q;
  assign bus_as_n    = bus_as_n_q;
  assign bus_rw      = bus_rw_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wr_data = bus_wr_data_q;

  // Arbiter must keep the grant until the access completes.
  a_grant_held: assert property (@(posedge clk) disable iff (!reset)
    (state_q == BUS_IF_ACCESS) |-> (bus_grnt_n == ENABLE_N));

endmodule
